seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Parametrised, time-multiplexed 7-segment display driver for DIGITS hex digits.
//   - Takes a packed BCD/hex value, per-digit decimal points and a leading-zero-blank mode.
//   - Scans one digit at a time, with a programmable dwell time and a ghost-suppression blank gap.
//   - Double-buffers the input so a new value never tears mid-frame.
//   - Drives the board's segment and digit-select pins directly.
// PARAMETERS
//   DIGITS        4     number of digits scanned, 1..16
//   PRESCALE      1000  clock cycles per digit slot; must be > BLANK_CYCLES
//   BLANK_CYCLES  2     cycles at the start of each slot with all outputs inactive, 0..PRESCALE-1
//   SEG_ACT_LOW   1     1: segment outputs active-low; 0: active-high
//   DIG_ACT_LOW   1     1: digit-select outputs active-low; 0: active-high
// PORTS
//   clk         in   1         system clock, rising edge
//   rst         in   1         synchronous reset, active-high
//   enable      in   1         1: scanning runs; 0: display dark, scan held at start
//   load        in   1         1-cycle strobe: capture value_in/dots_in/lz_blank_in into pending
//   value_in    in   4*DIGITS  nibble k = digit k (digit 0 = rightmost, least significant)
//   dots_in     in   DIGITS    bit k lights the decimal point of digit k
//   lz_blank_in in   1         1: blank leading zero digits
//   seg         out  8         {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//   dig         out  DIGITS    one-hot digit select, polarity per DIG_ACT_LOW
//   frame_done  out  1         1-cycle pulse when the last slot of a frame ends
// BEHAVIOUR
//   - Reset (overrides all): cnt=0, idx=0; pending and active regs = 0.
//     seg and dig inactive (all 1s when active-low); frame_done=0.
//   - Counters: cnt runs 0..PRESCALE-1. When cnt reaches PRESCALE-1, cnt wraps to 0 and idx steps by 1.
//     idx wraps from DIGITS-1 to 0. The wrap of idx to 0 is the frame boundary.
//   - enable=0: cnt and idx forced to 0, outputs inactive, frame_done=0. On enable=1 the scan restarts at digit 0.
//   - Load: when load=1, pending <= {value_in, dots_in, lz_blank_in}. A later load overwrites pending.
//   - Buffer swap: on the cycle where the frame boundary occurs, active <= pending (pre-edge contents).
//     If load coincides with the boundary, active takes the old pending. The new data shows one frame later.
//   - Outputs are registered. seg/dig/frame_done at cycle t+1 decode the (cnt, idx, active) state of cycle t.
//   - Blank gap: while cnt < BLANK_CYCLES, seg and dig are both fully inactive.
//   - Otherwise dig selects only bit idx. seg = hex encode of nibble idx plus dp = dots[idx].
//   - Encoding, gfedcba active-high, nibbles 0..F:
//     3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//     With SEG_ACT_LOW, the whole 8-bit word is inverted.
//   - Leading-zero blank (active lz=1): digit k is blank if nibbles k..DIGITS-1 are all 0 and k != 0.
//     Digit 0 is never blanked. A blank digit has gfedcba off, but dp still follows dots[k]. dig still selects it.
//   - frame_done: registered pulse, asserted for the slot ending at idx=DIGITS-1, cnt=PRESCALE-1.
//     It occurs once every DIGITS*PRESCALE cycles while enabled.
//   - DIGITS=1: idx stays 0, and every slot end is a frame boundary.
// TESTING  (DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, both polarities active-low)
//   - Reset: hold rst 2 cycles -> seg=8'hFF, dig=4'hF, frame_done=0. These hold until enable=1.
//   - Load 16'h1234, dots=0, lz=0, then run 2 frames. Second frame, in order:
//     dig=1110/seg=8'h99, dig=1101/seg=8'hB0, dig=1011/seg=8'hA4, dig=0111/seg=8'hF9.
//     Each slot is preceded by 1 cycle of dig=F/seg=FF.
//   - Timing: frame_done pulses every 16 cycles exactly. dig is active 3 of 4 cycles per slot.
//   - Leading zero: load 16'h0070, lz=1 -> digits 3,2 seg=8'hFF (dig active), digit 1 seg=8'hF8, digit 0 seg=8'hC0.
//     Load 16'h0000, lz=1 -> only digit 0 lit, seg=8'hC0.
//   - Tearing: load 16'h66B7 while idx=2 -> digits 2,3 still show the old value this frame.
//     From the next digit-0 slot: 8'hF8, 8'h83, 8'h82, 8'h82. Load on the boundary cycle itself -> applied one frame later.
//   - Dots and reset: dots_in=4'b1000 -> digit 3 seg bit7=0, others bit7=1.
//     rst asserted mid-slot at idx=2 -> next cycle outputs inactive, active cleared.
//     After release, the scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: scans DIGITS hex digits with a blank gap per slot,
// double-buffered display data and optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned SEG_ACT_LOW  = 1,
    parameter int unsigned DIG_ACT_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dots_in,
    input  logic                  lz_blank_in,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam logic [7:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VAL_W-1:0]  pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [DIGITS-1:0] pend_dots_q, pend_dots_d, act_dots_q, act_dots_d;
    logic              pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic              fd_q, fd_d;

    logic              slot_end, last_idx;
    logic [DIGITS-1:0] blank;
    logic [DIGITS-1:0] dig_raw;
    logic [7:0]        digit_seg [DIGITS];

    // Per-digit segment word; a digit is blank when it and everything above it is zero
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_lsd
            assign blank[k] = 1'b0;
        end else begin : g_upper
            assign blank[k] = act_lz_q & ~|act_val_q[VAL_W-1:4*k];
        end
        assign digit_seg[k] = {act_dots_q[k], blank[k] ? 7'h00 : hex7(act_val_q[4*k +: 4])};
    end

    always_comb begin
        slot_end    = (cnt_q == CNT_W'(PRESCALE - 1));
        last_idx    = (idx_q == IDX_W'(DIGITS - 1));
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        pend_val_d  = pend_val_q;
        pend_dots_d = pend_dots_q;
        pend_lz_d   = pend_lz_q;
        act_val_d   = act_val_q;
        act_dots_d  = act_dots_q;
        act_lz_d    = act_lz_q;
        seg_d       = SEG_OFF;
        dig_d       = DIG_OFF;
        fd_d        = 1'b0;
        dig_raw     = DIGITS'(1) << idx_q;

        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
        end

        if (load) begin
            pend_val_d  = value_in;
            pend_dots_d = dots_in;
            pend_lz_d   = lz_blank_in;
        end

        // Frame boundary swaps in the pre-edge pending contents
        if (enable && slot_end && last_idx) begin
            act_val_d  = pend_val_q;
            act_dots_d = pend_dots_q;
            act_lz_d   = pend_lz_q;
        end

        if (enable) begin
            fd_d = slot_end & last_idx;
            if (32'(cnt_q) >= BLANK_CYCLES) begin
                seg_d = digit_seg[idx_q] ^ SEG_OFF;
                dig_d = dig_raw ^ DIG_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_val_q  <= '0;
            pend_dots_q <= '0;
            pend_lz_q   <= 1'b0;
            act_val_q   <= '0;
            act_dots_q  <= '0;
            act_lz_q    <= 1'b0;
            seg_q       <= SEG_OFF;
            dig_q       <= DIG_OFF;
            fd_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_val_q  <= pend_val_d;
            pend_dots_q <= pend_dots_d;
            pend_lz_q   <= pend_lz_d;
            act_val_q   <= act_val_d;
            act_dots_q  <= act_dots_d;
            act_lz_q    <= act_lz_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
            fd_q        <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4-cycle slots, 1 blank cycle, active-low pins).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst, enable, load, lz_blank_in;
    logic [15:0] value_in;
    logic [3:0]  dots_in;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] ZERO4 = 32'hC0C0_C0C0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .value_in(value_in), .dots_in(dots_in), .lz_blank_in(lz_blank_in),
        .seg(seg), .dig(dig), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dark(input string tag);
        check({tag, " seg"}, 32'(seg), 32'h0000_00FF);
        check({tag, " dig"}, 32'(dig), 32'h0000_000F);
        check({tag, " fd"},  32'(frame_done), 32'h0);
    endtask

    // exp_segs holds the lit seg byte per digit as {d3,d2,d1,d0}; k is the position within the frame
    task automatic check_pos(input string name, input int k, input logic [31:0] exp_segs);
        int         slot;
        logic [3:0] ed;
        logic [7:0] es;
        slot = k / 4;
        if ((k % 4) == 0) begin
            ed = 4'hF;
            es = 8'hFF;
        end else begin
            ed = ~4'(4'b0001 << slot);
            es = exp_segs[slot*8 +: 8];
        end
        check($sformatf("%s k%0d dig", name, k), 32'(dig), 32'(ed));
        check($sformatf("%s k%0d seg", name, k), 32'(seg), 32'(es));
        check($sformatf("%s k%0d fd", name, k), 32'(frame_done), 32'(k == 15));
    endtask

    task automatic run_frame(input string name, input logic [31:0] exp_segs, input int n_ticks,
                             input int load_at, input logic [15:0] lv, input logic [3:0] ld,
                             input logic llz);
        for (int k = 0; k < n_ticks; k++) begin
            if (k == load_at) begin
                load        = 1'b1;
                value_in    = lv;
                dots_in     = ld;
                lz_blank_in = llz;
            end
            tick();
            load = 1'b0;
            check_pos(name, k, exp_segs);
        end
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        load        = 1'b0;
        value_in    = '0;
        dots_in     = '0;
        lz_blank_in = 1'b0;
        tick();
        tick();
        check_dark("reset");
        rst = 1'b0;

        // Load while disabled; display must stay dark until enable
        load     = 1'b1;
        value_in = 16'h1234;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_dark($sformatf("disabled%0d", i));
        end

        enable = 1'b1;
        run_frame("f0_zero",   ZERO4,         16, -1, 16'h0,    4'h0,    1'b0);
        run_frame("f1_1234",   32'hF9A4_B099, 16, -1, 16'h0,    4'h0,    1'b0);
        run_frame("f2_1234",   32'hF9A4_B099, 16,  0, 16'h0070, 4'h0,    1'b1);
        run_frame("f3_lz0070", 32'hFFFF_F8C0, 16,  0, 16'h0000, 4'h0,    1'b1);
        run_frame("f4_lz0000", 32'hFFFF_FFC0, 16,  8, 16'h66B7, 4'h0,    1'b0);
        run_frame("f5_66b7",   32'h8282_83F8, 16, 15, 16'h1234, 4'b1000, 1'b0);
        run_frame("f6_66b7",   32'h8282_83F8, 16, -1, 16'h0,    4'h0,    1'b0);
        run_frame("f7_dots",   32'h79A4_B099, 16, -1, 16'h0,    4'h0,    1'b0);
        run_frame("f8_pre",    32'h79A4_B099,  9, -1, 16'h0,    4'h0,    1'b0);

        // Reset mid-slot at digit 2 with enable still high
        rst = 1'b1;
        tick();
        check_dark("mid_rst");
        rst = 1'b0;
        run_frame("f9_post_rst", ZERO4, 16, -1, 16'h0, 4'h0, 1'b0);
        run_frame("f10_post_rst", ZERO4, 16, -1, 16'h0, 4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
